// File: rtl/mult_pkg.sv
// mult_pkg: shared FSM state type and counter-width helper for seq_multiplier_n.
package mult_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} mult_state_t;
  function automatic int cnt_w(input int width);
    return $clog2(width);
  endfunction
endpackage

// File: rtl/mult_addsub.sv
// mult_addsub: WIDTH+1-bit pass/add/subtract of accumulator a and multiplicand m.
// Ports: a, m (operands), mode (1 = sign-extend), add (a+m), sub (a-m, wins over add), s (result).
// With SEQ_MULT_TC_EN undefined only the unsigned pass/add path is built.
module mult_addsub #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] m,
  input  logic             mode,
  input  logic             add,
  input  logic             sub,
  output logic [WIDTH:0]   s
);
`ifdef SEQ_MULT_TC_EN
  logic [WIDTH:0] ea, em;
  assign ea = {mode & a[WIDTH-1], a};
  assign em = {mode & m[WIDTH-1], m};
  assign s  = sub ? ea - em : add ? ea + em : ea;
`else
  logic unused_ctl;
  assign unused_ctl = mode | sub;
  assign s = add ? {1'b0, a} + {1'b0, m} : {1'b0, a};
`endif
endmodule

// File: rtl/seq_multiplier_n.sv
// seq_multiplier_n: shift-and-add multiplier, one multiplier bit per clock, start/ready/done handshake.
// Ports: clock, n_rst (async active-low), start, Ain, Bin, tc (two's complement select) in;
//        ready, busy, done, product (2*WIDTH, = {A,Q}) out.
// Macro SEQ_MULT_TC_EN enables two's-complement mode; without it tc is ignored.
module seq_multiplier_n
  import mult_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 clock,
  input  logic                 n_rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     Ain,
  input  logic [WIDTH-1:0]     Bin,
  input  logic                 tc,
  output logic                 ready,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);
  localparam int CW = cnt_w(WIDTH);
  mult_state_t      state;
  logic [WIDTH-1:0] m, a, q;
  logic             mode, mode_in, last;
  logic [CW-1:0]    count;
  logic [WIDTH:0]   s;
`ifdef SEQ_MULT_TC_EN
  assign mode_in = tc;
`else
  logic unused_tc;
  assign unused_tc = tc;
  assign mode_in   = 1'b0;
`endif
  assign last = count == CW'(WIDTH - 1);
  // The sign bit of a two's-complement multiplier has negative weight,
  // so its partial product is subtracted on the final iteration.
  mult_addsub #(.WIDTH(WIDTH)) u_addsub (
    .a    (a),
    .m    (m),
    .mode (mode),
    .add  (q[0]),
    .sub  (mode & last & q[0]),
    .s    (s)
  );
  always_ff @(posedge clock or negedge n_rst) begin
    if (!n_rst) begin
      state <= IDLE;
      m     <= '0;
      a     <= '0;
      q     <= '0;
      mode  <= 1'b0;
      count <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          m     <= Ain;
          q     <= Bin;
          a     <= '0;
          mode  <= mode_in;
          count <= '0;
          state <= RUN;
        end
        RUN: begin
          a     <= s[WIDTH:1];
          q     <= {s[0], q[WIDTH-1:1]};
          count <= count + 1'b1;
          state <= last ? DONE : RUN;
        end
        default: state <= IDLE;
      endcase
    end
  end
  assign ready   = state == IDLE;
  assign busy    = state == RUN;
  assign done    = state == DONE;
  assign product = {a, q};
endmodule
